// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - op codes and helpers shared by the pipelined shifter
package shift_pkg;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  // Ceiling log2; the shift amount width for a power-of-two data width.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_pipe_if.sv
// rtl/shift_pipe_if.sv - request/result handshake bundle for the pipelined shifter
interface shift_pipe_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = shift_pkg::clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // Producer of requests / consumer of results.
  modport master (
    output in_valid, in_data, in_shamt, in_op, out_ready,
    input  in_ready, out_valid, out_data
  );

  // The shifter itself.
  modport slave (
    input  in_valid, in_data, in_shamt, in_op, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/shift_level.sv
// rtl/shift_level.sv - one barrel level, shifts or rotates by 2**LEVEL when enabled
module shift_level
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LEVEL = 0
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic             fill_bit,
  output logic [WIDTH-1:0] data_out
);

  localparam int AMT = 1 << LEVEL;
  // Upper AMT bits set; these are the positions an arithmetic right shift fills.
  localparam logic [WIDTH-1:0] FILL_MASK = ~({WIDTH{1'b1}} >> AMT);

  // Select the shifted/rotated word; unknown ops and a clear enable pass data through.
  always_comb begin
    data_out = data_in;
    if (en) begin
      case (op)
        OP_SLL:  data_out = data_in << AMT;
        OP_SRL:  data_out = data_in >> AMT;
        OP_SRA:  data_out = (data_in >> AMT) | (fill_bit ? FILL_MASK : '0);
        OP_ROL:  data_out = (data_in << AMT) | (data_in >> (WIDTH - AMT));
        OP_ROR:  data_out = (data_in >> AMT) | (data_in << (WIDTH - AMT));
        default: data_out = data_in;
      endcase
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// rtl/shift_pipe.sv - two-stage pipelined barrel shifter/rotator with valid/ready on both sides
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SPLIT = 3
) (
  input  logic         m_clock,
  input  logic         p_reset,
  shift_pipe_if.slave  bus,
  output logic         busy
);

  localparam int SHW = clog2(WIDTH);
  // Stage-2 shift bits; kept at least one bit wide so SPLIT == SHW still elaborates.
  localparam int HIW = (SHW > SPLIT) ? (SHW - SPLIT) : 1;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q,  s1_data_d;
  logic [2:0]       s1_op_q,    s1_op_d;
  logic [HIW-1:0]   s1_hi_q,    s1_hi_d;
  logic             s1_sign_q,  s1_sign_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;

  logic             s1_adv;
  logic             s2_adv;
  logic [HIW-1:0]   in_hi;

  logic [WIDTH-1:0] s1_chain [SPLIT+1];
  logic [WIDTH-1:0] s2_chain [SHW-SPLIT+1];

  assign s2_adv       = !out_valid_q || bus.out_ready;
  assign s1_adv       = !s1_valid_q || s2_adv;
  assign bus.in_ready = s1_adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = s1_valid_q || out_valid_q;

  // Low barrel levels work on the incoming operand; SRA fills from its own MSB.
  assign s1_chain[0] = bus.in_data;
  for (genvar k = 0; k < SPLIT; k++) begin : g_s1_level
    shift_level #(.WIDTH(WIDTH), .LEVEL(k)) u_level (
      .data_in  (s1_chain[k]),
      .en       (bus.in_shamt[k]),
      .op       (bus.in_op),
      .fill_bit (bus.in_data[WIDTH-1]),
      .data_out (s1_chain[k+1])
    );
  end

  // High barrel levels work on the registered partial result with the carried sign.
  assign s2_chain[0] = s1_data_q;
  for (genvar k = 0; k < SHW - SPLIT; k++) begin : g_s2_level
    shift_level #(.WIDTH(WIDTH), .LEVEL(SPLIT + k)) u_level (
      .data_in  (s2_chain[k]),
      .en       (s1_hi_q[k]),
      .op       (s1_op_q),
      .fill_bit (s1_sign_q),
      .data_out (s2_chain[k+1])
    );
  end

  if (SPLIT < SHW) begin : g_hi
    assign in_hi = bus.in_shamt[SHW-1:SPLIT];
  end else begin : g_no_hi
    // Stage 2 is a plain register here, so the carried op/sign/shamt have no reader.
    logic unused_s2_ctrl;
    assign in_hi          = '0;
    assign unused_s2_ctrl = ^{s1_hi_q, s1_sign_q, s1_op_q};
  end

  // Stage-1 next state: capture an accepted request, or empty out when it moves on.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_op_d    = s1_op_q;
    s1_hi_d    = s1_hi_q;
    s1_sign_d  = s1_sign_q;
    if (s1_adv) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_data_d = s1_chain[SPLIT];
        s1_op_d   = bus.in_op;
        s1_hi_d   = in_hi;
        s1_sign_d = bus.in_data[WIDTH-1];
      end
    end
  end

  // Stage-2 next state: result only changes when the output slot is free to move.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) out_data_d = s2_chain[SHW-SPLIT];
    end
  end

  // Pipeline registers; reset drops anything in flight.
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_op_q     <= '0;
      s1_hi_q     <= '0;
      s1_sign_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_op_q     <= s1_op_d;
      s1_hi_q     <= s1_hi_d;
      s1_sign_q   <= s1_sign_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule
